// File: rtl/uart_pkg.sv
// Shared UART frame constants, FSM state types and the parity helper used
// by both the transmit and receive paths of uart_link.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // Even parity when odd=0: data plus parity bit carries an even count of ones.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable down-counter: a load at one edge makes tick high in the cycle
// before the edge that lies load_value cycles later.
module uart_bit_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick
);

  logic [WIDTH-1:0] count_reg;
  logic             active_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      count_reg  <= load_value - WIDTH'(1);
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (count_reg == '0) begin
        active_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - WIDTH'(1);
      end
    end
  end

  assign tick = active_reg && (count_reg == '0);

endmodule

// File: rtl/uart_link.sv
// Full-duplex 8-bit UART (start, 8 data LSB-first, parity, stop) with
// independent TX and RX state machines sharing one clock.
module uart_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_to_tx,
  input  logic       start_tx,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] data_received,
  output logic       rx_done,
  output logic       parity_error
);

  localparam int             TW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0]  FULL_BIT  = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0]  HALF_BIT  = TW'(CLKS_PER_BIT / 2);
  localparam logic           ODD       = (PARITY_ODD != 0);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  // ---------------- transmit path ----------------
  tx_state_t             tx_state_reg;
  logic [DATA_BITS-1:0]  tx_shift_reg;
  logic [2:0]            tx_idx_reg;
  logic                  tx_par_reg;
  logic                  tx_reg;
  logic                  tx_busy_reg;
  logic                  tx_tick;
  logic                  tx_timer_load;

  assign tx_timer_load = ((tx_state_reg == TX_IDLE) && start_tx) ||
                         (tx_tick && (tx_state_reg != TX_STOP));

  uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tx_timer_load),
    .load_value (FULL_BIT),
    .tick       (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '0;
      tx_idx_reg   <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (start_tx) begin
            tx_shift_reg <= data_to_tx;
            tx_par_reg   <= parity_bit(data_to_tx, ODD);
            tx_reg       <= START_BIT;
            tx_busy_reg  <= 1'b1;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_reg       <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_idx_reg   <= '0;
            tx_state_reg <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_idx_reg == LAST_BIT) begin
              tx_reg       <= tx_par_reg;
              tx_state_reg <= TX_PARITY;
            end else begin
              tx_reg       <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_idx_reg   <= tx_idx_reg + 3'd1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_tick) begin
            tx_reg       <= STOP_BIT;
            tx_state_reg <= TX_STOP;
          end
        end
        TX_STOP: begin
          // Dropping to IDLE guarantees at least one idle cycle between frames.
          if (tx_tick) begin
            tx_reg       <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_state_reg <= TX_IDLE;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = tx_busy_reg;

  // ---------------- receive path ----------------
  logic                  rx_meta_reg;
  logic                  rx_sync_reg;
  logic                  rx_prev_reg;
  logic                  rx_fall;
  rx_state_t             rx_state_reg;
  logic [DATA_BITS-1:0]  rx_shift_reg;
  logic [2:0]            rx_idx_reg;
  logic                  rx_par_reg;
  logic [7:0]            data_received_reg;
  logic                  rx_done_reg;
  logic                  parity_error_reg;
  logic                  rx_tick;
  logic                  rx_timer_load;
  logic [TW-1:0]         rx_timer_value;

  // Synchroniser flops reset to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign rx_fall = rx_prev_reg && !rx_sync_reg;

  assign rx_timer_load = ((rx_state_reg == RX_IDLE) && rx_fall) ||
                         (rx_tick && (((rx_state_reg == RX_START) && (rx_sync_reg == START_BIT)) ||
                                      (rx_state_reg == RX_DATA) ||
                                      (rx_state_reg == RX_PARITY)));
  assign rx_timer_value = (rx_state_reg == RX_IDLE) ? HALF_BIT : FULL_BIT;

  uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (rx_timer_load),
    .load_value (rx_timer_value),
    .tick       (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg      <= RX_IDLE;
      rx_shift_reg      <= '0;
      rx_idx_reg        <= '0;
      rx_par_reg        <= 1'b0;
      data_received_reg <= '0;
      rx_done_reg       <= 1'b0;
      parity_error_reg  <= 1'b0;
    end else begin
      rx_done_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_fall) rx_state_reg <= RX_START;
        end
        RX_START: begin
          if (rx_tick) begin
            rx_idx_reg   <= '0;
            rx_state_reg <= (rx_sync_reg == START_BIT) ? RX_DATA : RX_IDLE;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_idx_reg == LAST_BIT) begin
              rx_state_reg <= RX_PARITY;
            end else begin
              rx_idx_reg <= rx_idx_reg + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_par_reg   <= rx_sync_reg;
            rx_state_reg <= RX_STOP;
          end
        end
        RX_STOP: begin
          // A low stop bit is still reported; the line must go idle before re-arming.
          if (rx_tick) begin
            data_received_reg <= rx_shift_reg;
            parity_error_reg  <= (rx_par_reg != parity_bit(rx_shift_reg, ODD));
            rx_done_reg       <= 1'b1;
            rx_state_reg      <= (rx_sync_reg == STOP_BIT) ? RX_IDLE : RX_WAIT_IDLE;
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_sync_reg) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign data_received = data_received_reg;
  assign rx_done       = rx_done_reg;
  assign parity_error  = parity_error_reg;

endmodule

// File: tb/tb_uart_link.sv
// Directed self-checking bench for uart_link: loopback frames, held request,
// parity/framing errors driven on rx, glitch rejection and mid-frame reset.
module tb_uart_link;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_to_tx = 8'h00;
  logic       start_tx = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       rx_line;
  logic       rx_drive = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int busy0;
  int done0;
  int done_at;

  assign rx_line = loop_en ? tx : rx_drive;

  uart_link #(.CLKS_PER_BIT(16), .PARITY_ODD(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_to_tx    (data_to_tx),
    .start_tx      (start_tx),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .rx            (rx_line),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_busy) busy_cnt <= busy_cnt + 1;
    if (rx_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at cycle 0 of a frame (first negedge after the start edge); samples
  // every bit mid-way and returns at cycle 168.
  task automatic check_tx_frame(input logic [7:0] d, input logic p, input string tag);
    logic [10:0] fb;
    fb = {1'b1, p, d, 1'b0};
    check({tag, "_fall"}, tx, 0);
    check({tag, "_busy"}, tx_busy, 1);
    for (int k = 0; k < 11; k++) begin
      repeat ((k == 0) ? 8 : 16) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, k), tx, fb[k]);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] fb;
    fb = {s, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rx_drive = fb[k];
      repeat (16) @(negedge clk);
    end
    rx_drive = 1'b1;
  endtask

  initial begin
    // Reset
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", rx_done, 0);
    check("rst_data", data_received, 8'h00);
    check("rst_perr", parity_error, 0);
    reset = 1'b0;
    loop_en = 1'b1;
    repeat (4) @(negedge clk);

    // Single loopback frame 0xB3 (five ones -> even parity bit 1)
    data_to_tx = 8'hB3;
    start_tx = 1'b1;
    busy0 = busy_cnt;
    done0 = done_cnt;
    @(negedge clk);
    start_tx = 1'b0;
    check_tx_frame(8'hB3, 1'b1, "b3");
    done_at = -1;
    for (int c = 169; c <= 200; c++) begin
      @(negedge clk);
      if (rx_done && done_at < 0) done_at = c;
    end
    check("b3_done_cycle", done_at, 171);
    check("b3_done_cnt", done_cnt - done0, 1);
    check("b3_busy_cycles", busy_cnt - busy0, 176);
    check("b3_data", data_received, 8'hB3);
    check("b3_perr", parity_error, 0);

    // Held request: two back-to-back frames with a single idle cycle
    data_to_tx = 8'hB3;
    start_tx = 1'b1;
    busy0 = busy_cnt;
    done0 = done_cnt;
    @(negedge clk);
    repeat (176) @(negedge clk);
    check("held_gap_tx", tx, 1);
    check("held_gap_busy", tx_busy, 0);
    @(negedge clk);
    check("held_2nd_tx", tx, 0);
    check("held_2nd_busy", tx_busy, 1);
    repeat (72) @(negedge clk);
    start_tx = 1'b0;
    repeat (351) @(negedge clk);
    check("held_done_cnt", done_cnt - done0, 2);
    check("held_busy_cyc", busy_cnt - busy0, 352);
    check("held_data", data_received, 8'hB3);
    check("held_perr", parity_error, 0);
    check("held_idle", tx_busy, 0);

    // Second byte 0x12 (two ones -> parity bit 0)
    data_to_tx = 8'h12;
    start_tx = 1'b1;
    done0 = done_cnt;
    @(negedge clk);
    start_tx = 1'b0;
    data_to_tx = 8'hFF;
    check_tx_frame(8'h12, 1'b0, "x12");
    repeat (32) @(negedge clk);
    check("x12_done_cnt", done_cnt - done0, 1);
    check("x12_data", data_received, 8'h12);
    check("x12_perr", parity_error, 0);
    repeat (50) @(negedge clk);
    check("x12_hold", data_received, 8'h12);

    // Parity error driven directly on rx, then a good frame clears it
    loop_en = 1'b0;
    rx_drive = 1'b1;
    repeat (5) @(negedge clk);
    done0 = done_cnt;
    send_rx(8'h12, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("perr_done_cnt", done_cnt - done0, 1);
    check("perr_data", data_received, 8'h12);
    check("perr_flag", parity_error, 1);
    done0 = done_cnt;
    send_rx(8'h5A, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("good_done_cnt", done_cnt - done0, 1);
    check("good_data", data_received, 8'h5A);
    check("good_perr", parity_error, 0);

    // Framing error: low stop bit, line held low, then recovery
    done0 = done_cnt;
    send_rx(8'hC3, 1'b0, 1'b0);
    rx_drive = 1'b0;
    repeat (30) @(negedge clk);
    check("frm_done_cnt", done_cnt - done0, 1);
    check("frm_data", data_received, 8'hC3);
    rx_drive = 1'b1;
    repeat (5) @(negedge clk);
    done0 = done_cnt;
    send_rx(8'hA5, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("frm_rec_cnt", done_cnt - done0, 1);
    check("frm_rec_data", data_received, 8'hA5);

    // Glitch: 3-cycle low pulse must not produce a frame
    done0 = done_cnt;
    rx_drive = 1'b0;
    repeat (3) @(negedge clk);
    rx_drive = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_done", done_cnt - done0, 0);
    check("glitch_data", data_received, 8'hA5);

    // Reset in the middle of a loopback frame
    loop_en = 1'b1;
    data_to_tx = 8'hFF;
    start_tx = 1'b1;
    done0 = done_cnt;
    @(negedge clk);
    start_tx = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_tx", tx, 1);
    check("mrst_busy", tx_busy, 0);
    check("mrst_done", rx_done, 0);
    reset = 1'b0;
    repeat (250) @(negedge clk);
    check("mrst_done_cnt", done_cnt - done0, 0);
    check("mrst_data", data_received, 8'h00);
    check("mrst_idle_tx", tx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
